// File: rtl/stopwatch_core.sv
// Start/stop/clear/lap stopwatch that counts tick strobes into sub/sec/min/hour digits.
// The display registers show either the live count or a frozen lap capture.
module stopwatch_core #(
  parameter int TICKS_PER_SEC = 10,
  parameter int SEC_MAX       = 60,
  parameter int MIN_MAX       = 60,
  parameter int HOUR_MAX      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [6:0] disp_sub,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [4:0] disp_hour,
  output logic       running,
  output logic       lap_hold,
  output logic       rollover,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] sub_q, sub_d, lap_sub_q, lap_sub_d, dsub_q, dsub_d;
  logic [5:0] sec_q, sec_d, lap_sec_q, lap_sec_d, dsec_q, dsec_d;
  logic [5:0] min_q, min_d, lap_min_q, lap_min_d, dmin_q, dmin_d;
  logic [4:0] hour_q, hour_d, lap_hour_q, lap_hour_d, dhour_q, dhour_d;
  logic       lap_hold_q, lap_hold_d;
  logic       rollover_q, rollover_d;
  logic       running_q, running_d;

  logic count_en;
  logic sub_wrap, sec_wrap, min_wrap, hour_wrap;

  assign count_en  = tick && (state_q == S_RUN);
  assign sub_wrap  = (sub_q  == 7'(TICKS_PER_SEC - 1));
  assign sec_wrap  = (sec_q  == 6'(SEC_MAX - 1));
  assign min_wrap  = (min_q  == 6'(MIN_MAX - 1));
  assign hour_wrap = (hour_q == 5'(HOUR_MAX - 1));

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    lap_sub_d  = lap_sub_q;
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    lap_hour_d = lap_hour_q;
    lap_hold_d = lap_hold_q;
    rollover_d = 1'b0;

    // Carry chain: each digit only moves when every lower digit wraps.
    if (count_en) begin
      if (!sub_wrap) begin
        sub_d = sub_q + 7'd1;
      end else begin
        sub_d = '0;
        if (!sec_wrap) begin
          sec_d = sec_q + 6'd1;
        end else begin
          sec_d = '0;
          if (!min_wrap) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d = '0;
            if (!hour_wrap) begin
              hour_d = hour_q + 5'd1;
            end else begin
              hour_d     = '0;
              rollover_d = 1'b1;
            end
          end
        end
      end
    end

    // Lap decisions use the pre-edge state; capture takes post-update live values.
    if (btn_lap) begin
      if (state_q == S_RUN && !lap_hold_q) begin
        lap_sub_d  = sub_d;
        lap_sec_d  = sec_d;
        lap_min_d  = min_d;
        lap_hour_d = hour_d;
        lap_hold_d = 1'b1;
      end else if (lap_hold_q && (state_q == S_RUN || state_q == S_STOP)) begin
        lap_hold_d = 1'b0;
      end
    end

    if (btn_run_stop) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_STOP;
        S_STOP:  state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end

    if (btn_clear) begin
      state_d    = S_IDLE;
      sub_d      = '0;
      sec_d      = '0;
      min_d      = '0;
      hour_d     = '0;
      lap_sub_d  = '0;
      lap_sec_d  = '0;
      lap_min_d  = '0;
      lap_hour_d = '0;
      lap_hold_d = 1'b0;
      rollover_d = 1'b0;
    end

    running_d = (state_d == S_RUN);
    dsub_d    = lap_hold_d ? lap_sub_d  : sub_d;
    dsec_d    = lap_hold_d ? lap_sec_d  : sec_d;
    dmin_d    = lap_hold_d ? lap_min_d  : min_d;
    dhour_d   = lap_hold_d ? lap_hour_d : hour_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sub_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      lap_sub_q  <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
      lap_hold_q <= 1'b0;
      rollover_q <= 1'b0;
      running_q  <= 1'b0;
      dsub_q     <= '0;
      dsec_q     <= '0;
      dmin_q     <= '0;
      dhour_q    <= '0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      lap_sub_q  <= lap_sub_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      lap_hour_q <= lap_hour_d;
      lap_hold_q <= lap_hold_d;
      rollover_q <= rollover_d;
      running_q  <= running_d;
      dsub_q     <= dsub_d;
      dsec_q     <= dsec_d;
      dmin_q     <= dmin_d;
      dhour_q    <= dhour_d;
    end
  end

  assign disp_sub  = dsub_q;
  assign disp_sec  = dsec_q;
  assign disp_min  = dmin_q;
  assign disp_hour = dhour_q;
  assign running   = running_q;
  assign lap_hold  = lap_hold_q;
  assign rollover  = rollover_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: scenario tasks plus random traffic, checked against
// a model that keeps the elapsed time as one tick total and decodes digits by division.
module tb_stopwatch_core;

  localparam int T      = 10;
  localparam int S      = 8;
  localparam int M      = 3;
  localparam int H      = 3;
  localparam int PERIOD = T * S * M * H;
  localparam int W      = 27;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       btn_run_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic [6:0] disp_sub;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic [4:0] disp_hour;
  logic       running;
  logic       lap_hold;
  logic       rollover;
  logic [1:0] dbg_state;

  stopwatch_core #(
    .TICKS_PER_SEC(T),
    .SEC_MAX(S),
    .MIN_MAX(M),
    .HOUR_MAX(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .btn_run_stop(btn_run_stop),
    .btn_clear(btn_clear),
    .btn_lap(btn_lap),
    .disp_sub(disp_sub),
    .disp_sec(disp_sec),
    .disp_min(disp_min),
    .disp_hour(disp_hour),
    .running(running),
    .lap_hold(lap_hold),
    .rollover(rollover),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: 0 idle, 1 run, 2 stop
  int   m_st;
  int   m_total;
  int   m_lap;
  logic m_hold;
  logic m_roll;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp;

  function automatic logic [W-1:0] model_vec();
    int v;
    v = m_hold ? m_lap : m_total;
    return {5'(v / (T * S * M)), 6'((v / (T * S)) % M), 6'((v / T) % S), 7'(v % T),
            (m_st == 1), m_hold, m_roll};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {disp_hour, disp_min, disp_sec, disp_sub, running, lap_hold, rollover};
  endfunction

  task automatic model_reset();
    m_st = 0; m_total = 0; m_lap = 0; m_hold = 1'b0; m_roll = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic t, input logic rs, input logic cl, input logic lp);
    if (cl) begin
      m_st = 0; m_total = 0; m_lap = 0; m_hold = 1'b0; m_roll = 1'b0;
    end else begin
      m_roll = 1'b0;
      if (t && m_st == 1) begin
        m_total = m_total + 1;
        if (m_total == PERIOD) begin
          m_total = 0;
          m_roll  = 1'b1;
        end
      end
      if (lp) begin
        if (m_st == 1 && !m_hold) begin
          m_lap  = m_total;
          m_hold = 1'b1;
        end else if (m_hold) begin
          m_hold = 1'b0;
        end
      end
      if (rs) m_st = (m_st == 1) ? 2 : 1;
    end
  endtask

  // driver: called at a negedge, returns at the next negedge with outputs settled
  task automatic step(input logic t, input logic rs, input logic cl, input logic lp);
    tick = t; btn_run_stop = rs; btn_clear = cl; btn_lap = lp;
    @(posedge clk);
    model_edge(t, rs, cl, lp);
    exp_q.push_back(model_vec());
    #1;
    tick = 1'b0; btn_run_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (dut_vec() !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h state %0d, expected 0 state 0", dut_vec(), dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_idle_tick %0d: got %h expected %h", i, got, exp);
      end
    end
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_no_count: got %h expected 0", dut_vec());
    end
  endtask

  task automatic test_run_stop();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL run_count %0d: got %h expected %h", i, got, exp);
      end
    end
    vectors++;
    if (disp_sub !== 7'd5 || disp_sec !== 6'd2 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL run_25: got sub %0d sec %0d run %b expected 5 2 1", disp_sub, disp_sec, running);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    vectors++;
    if (disp_sub !== 7'd5 || disp_sec !== 6'd2 || running !== 1'b0 || dbg_state !== 2'd2) begin
      miscompares++;
      $display("FAIL stop_hold: got sub %0d sec %0d run %b st %0d expected 5 2 0 2",
               disp_sub, disp_sec, running, dbg_state);
    end
  endtask

  task automatic test_rollover();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < PERIOD - 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL preload %0d: got %h expected %h", i, got, exp);
      end
    end
    vectors++;
    if ({disp_hour, disp_min, disp_sec, disp_sub} !== {5'd2, 6'd2, 6'd7, 7'd8}) begin
      miscompares++;
      $display("FAIL preload_max: got %0d:%0d:%0d.%0d expected 2:2:7.8",
               disp_hour, disp_min, disp_sec, disp_sub);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    vectors++;
    if (disp_sub !== 7'd9 || rollover !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_wrap: got sub %0d roll %b expected 9 0", disp_sub, rollover);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    vectors++;
    if ({disp_hour, disp_min, disp_sec, disp_sub} !== '0 || rollover !== 1'b1 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: got %0d:%0d:%0d.%0d roll %b run %b expected 0:0:0.0 1 1",
               disp_hour, disp_min, disp_sec, disp_sub, rollover, running);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    vectors++;
    if (rollover !== 1'b0) begin
      miscompares++;
      $display("FAIL rollover_pulse: got %b expected 0", rollover);
    end
  endtask

  task automatic test_lap();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    vectors++;
    if (lap_hold !== 1'b1 || disp_sec !== 6'd3 || disp_sub !== 7'd0) begin
      miscompares++;
      $display("FAIL lap_capture: got hold %b %0d.%0d expected 1 3.0", lap_hold, disp_sec, disp_sub);
    end
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    vectors++;
    if (lap_hold !== 1'b1 || disp_sec !== 6'd3 || disp_sub !== 7'd0) begin
      miscompares++;
      $display("FAIL lap_frozen: got hold %b %0d.%0d expected 1 3.0", lap_hold, disp_sec, disp_sub);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    vectors++;
    if (lap_hold !== 1'b0 || disp_sec !== 6'd4 || disp_sub !== 7'd2) begin
      miscompares++;
      $display("FAIL lap_release: got hold %b %0d.%0d expected 0 4.2", lap_hold, disp_sec, disp_sub);
    end
  endtask

  task automatic test_clear_priority();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (74) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    vectors++;
    if (disp_sec !== 6'd7 || disp_sub !== 7'd4) begin
      miscompares++;
      $display("FAIL clear_pre: got %0d.%0d expected 7.4", disp_sec, disp_sub);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    exp_q.delete();
    vectors++;
    if (dut_vec() !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL clear_priority: got %h state %0d expected 0 state 0", dut_vec(), dbg_state);
    end
  endtask

  task automatic test_start_tick();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    vectors++;
    if (running !== 1'b1 || disp_sub !== 7'd0) begin
      miscompares++;
      $display("FAIL start_tick: got run %b sub %0d expected 1 0", running, disp_sub);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    vectors++;
    if (disp_sub !== 7'd1) begin
      miscompares++;
      $display("FAIL first_count: got sub %0d expected 1", disp_sub);
    end
  endtask

  task automatic test_random();
    logic t, rs, cl, lp;
    for (int i = 0; i < 3000; i++) begin
      t  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 199) == 0);
      lp = ($urandom_range(0, 11) == 0);
      step(t, rs, cl, lp);
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (17) step(1'b1, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (dut_vec() !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h state %0d expected 0 state 0", dut_vec(), dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    got = dut_vec(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_after: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_run_stop();
    test_rollover();
    test_lap();
    test_clear_priority();
    test_start_tick();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
